// File: rtl/decode_inst_buffer.sv
// decode_inst_buffer: instruction buffer between Decode and Rename.
//   Valid Decode lanes are compacted into a circular FIFO. Dispatch groups of
//   the oldest entries are presented to Rename, with lane 0 the oldest.
//   Optional feature macro: IB_PARTIAL_DISPATCH_EN. When it is defined,
//   partial dispatch groups of min(count, DISPATCH_WIDTH) lanes are allowed.
//   When it is undefined, a group is presented only when DISPATCH_WIDTH
//   entries are buffered.
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   flush_i         squash all buffered entries
//   stall_i         Rename cannot accept this cycle
//   decReady_i      Decode bundle present
//   decValid_i      per-lane valid of the Decode bundle
//   decPacket_i     Decode lanes; lane i at [i*PKT_W +: PKT_W]
//   stall_o         buffer cannot absorb a full bundle (combinational)
//   renValid_o      per-lane valid toward Rename
//   renPacket_o     oldest entries, lane 0 = oldest (combinational)
//   renReady_o      a dispatch group is presented
//   count_o         current occupancy
module decode_inst_buffer #(
  parameter int unsigned FETCH_WIDTH    = 4,
  parameter int unsigned DISPATCH_WIDTH = 4,
  parameter int unsigned DEPTH          = 32,
  parameter int unsigned PKT_W          = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush_i,
  input  logic                              stall_i,
  input  logic                              decReady_i,
  input  logic [FETCH_WIDTH-1:0]            decValid_i,
  input  logic [FETCH_WIDTH*PKT_W-1:0]      decPacket_i,
  output logic                              stall_o,
  output logic [DISPATCH_WIDTH-1:0]         renValid_o,
  output logic [DISPATCH_WIDTH*PKT_W-1:0]   renPacket_o,
  output logic                              renReady_o,
  output logic [$clog2(DEPTH):0]            count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [PKT_W-1:0] r_mem [DEPTH];

  logic             w_wr_en;
  logic             w_rd_en;
  logic [CW-1:0]    w_nwr;
  logic [CW-1:0]    w_wr_cnt;
  logic [CW-1:0]    w_nrd;
  logic [AW-1:0]    w_waddr [FETCH_WIDTH];

  // Stall is based on current occupancy, so same-cycle reads never free space for writes.
  assign stall_o  = (r_count > CW'(DEPTH - FETCH_WIDTH));
  assign w_wr_en  = decReady_i & ~stall_o & ~flush_i;
  assign w_wr_cnt = w_wr_en ? w_nwr : '0;
  assign count_o  = r_count;

  // Compaction: each valid lane lands at tail + (number of valid lanes below it).
  always_comb begin : wr_compact
    w_nwr = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_waddr[i] = r_tail + AW'(w_nwr);
      w_nwr      = w_nwr + CW'(decValid_i[i]);
    end
  end

  // Dispatch group selection and read port.
  always_comb begin : rd_group
    renValid_o  = '0;
    renPacket_o = '0;
    w_nrd       = '0;
`ifdef IB_PARTIAL_DISPATCH_EN
    renReady_o = (r_count != '0);
    for (int j = 0; j < DISPATCH_WIDTH; j++) begin
      renValid_o[j] = (r_count > CW'(j));
    end
`else
    renReady_o = (r_count >= CW'(DISPATCH_WIDTH));
    renValid_o = {DISPATCH_WIDTH{renReady_o}};
`endif
    w_rd_en = renReady_o & ~stall_i & ~flush_i;
    for (int j = 0; j < DISPATCH_WIDTH; j++) begin
      if (w_rd_en) begin
        w_nrd = w_nrd + CW'(renValid_o[j]);
      end
      renPacket_o[j*PKT_W +: PKT_W] = r_mem[r_head + AW'(j)];
    end
  end

  // Pointer and occupancy registers; flush empties the buffer and drops same-cycle traffic.
  always_ff @(posedge clk) begin : ptr_regs
    if (reset || flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_nrd);
      r_tail  <= r_tail + AW'(w_wr_cnt);
      r_count <= r_count + w_wr_cnt - w_nrd;
    end
  end

  // Storage has no reset; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin : mem_write
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (w_wr_en && decValid_i[i]) begin
        r_mem[w_waddr[i]] <= decPacket_i[i*PKT_W +: PKT_W];
      end
    end
  end

`ifndef SYNTHESIS
  // Occupancy and pointer consistency checks.
  always @(posedge clk) begin
    if (!reset) begin
      a_count_max: assert (r_count <= CW'(DEPTH));
      a_count_min: assert (w_nrd <= r_count);
      a_ptr_sync:  assert (AW'(r_tail - r_head) == AW'(r_count));
    end
  end
`endif

endmodule
